ialu_issue_ctrl: RTL and testbench

//  EX-stage initiator for the integer ALU: accepts one decoded op from ID (valid/ready) and drives the ALU operand/control inputs.

---
 rtl/ialu_issue_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_ialu_issue_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ialu_issue_ctrl.sv
// ialu_issue_ctrl: EX-stage initiator for the integer ALU.
// Accepts one decoded op from ID (valid/ready), drives the ALU operand and control inputs,
// holds a divide request until the divider reports done (or a timeout expires), samples the
// ALU's registered result and flags, and presents a single-cycle writeback beat.
// One op in flight at a time; id_ready is low while an op is in flight.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   flush                      synchronous kill of the in-flight op, highest priority
//   id_valid/id_ready          ID handshake
//   id_rs1, id_rs2, id_rd      operands and destination register
//   id_reg_write               op writes rd
//   id_ialu_ctrl               unit select (000 add/sub ... 101 shift, 110/111 no result)
//   id_funct3, id_funct7_5,
//   id_add_op                  passthrough controls for the ALU
//   alu_*  (out)               ALU operands/controls; alu_ctrl = 3'b111 when idle
//   alu_result, alu_overflow   ALU registered result and overflow
//   alu_div_done,
//   alu_div_by_zero            divider handshake and zero-divisor flag
//   wb_*                       writeback beat and its fields
module ialu_issue_ctrl #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned DIV_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [XLEN-1:0]   id_rs1,
    input  logic [XLEN-1:0]   id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic [2:0]        id_ialu_ctrl,
    input  logic [2:0]        id_funct3,
    input  logic              id_funct7_5,
    input  logic              id_add_op,
    output logic [XLEN-1:0]   alu_rs1,
    output logic [XLEN-1:0]   alu_rs2,
    output logic [2:0]        alu_ctrl,
    output logic [2:0]        alu_funct3,
    output logic              alu_funct7_5,
    output logic              alu_add_op,
    input  logic [XLEN-1:0]   alu_result,
    input  logic              alu_overflow,
    input  logic              alu_div_done,
    input  logic              alu_div_by_zero,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              wb_overflow,
    output logic              wb_div_by_zero,
    output logic              wb_div_timeout
);

    localparam int unsigned CntW = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DIV_TIMEOUT - 1);
    localparam logic [2:0] CtrlAdd  = 3'b000;
    localparam logic [2:0] CtrlDiv  = 3'b010;
    localparam logic [2:0] CtrlIdle = 3'b111;

    typedef enum logic [1:0] {StIdle, StIssue, StDivWait, StCapt} state_e;

    state_e state_q, state_d;

    logic [XLEN-1:0]   op_rs1_q, op_rs2_q;
    logic [REG_AW-1:0] op_rd_q;
    logic              op_we_q;
    logic [2:0]        op_ctrl_q, op_funct3_q;
    logic              op_funct7_5_q, op_add_op_q;

    logic [CntW-1:0] div_cnt_q, div_cnt_d;
    logic            div_bz_q, div_bz_d;
    logic            div_to_q, div_to_d;

    logic accept;
    logic capt_fire;

    assign id_ready  = (state_q == StIdle) && !flush;
    assign accept    = id_valid && id_ready;
    // A flush in CAPT kills the beat as well.
    assign capt_fire = (state_q == StCapt) && !flush;

    assign alu_rs1      = op_rs1_q;
    assign alu_rs2      = op_rs2_q;
    assign alu_funct3   = op_funct3_q;
    assign alu_funct7_5 = op_funct7_5_q;
    assign alu_add_op   = op_add_op_q;
    // Holding ctrl at 010 through DIV_WAIT keeps the divider's data_valid asserted.
    assign alu_ctrl = (state_q == StIssue || state_q == StDivWait) ? op_ctrl_q : CtrlIdle;

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        div_bz_d  = div_bz_q;
        div_to_d  = div_to_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StIssue;
            end
            StIssue: begin
                div_bz_d = 1'b0;
                div_to_d = 1'b0;
                if (op_ctrl_q == CtrlDiv) begin
                    state_d   = StDivWait;
                    div_cnt_d = '0;
                end else begin
                    state_d = StCapt;
                end
            end
            StDivWait: begin
                div_cnt_d = div_cnt_q + 1'b1;
                if (alu_div_done) begin
                    div_bz_d = alu_div_by_zero;
                    state_d  = StCapt;
                end else if (div_cnt_q == CntLast) begin
                    div_to_d = 1'b1;
                    state_d  = StCapt;
                end
            end
            StCapt: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (flush) state_d = StIdle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            div_cnt_q <= '0;
            div_bz_q  <= 1'b0;
            div_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            div_bz_q  <= div_bz_d;
            div_to_q  <= div_to_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_rs1_q      <= '0;
            op_rs2_q      <= '0;
            op_rd_q       <= '0;
            op_we_q       <= 1'b0;
            op_ctrl_q     <= '0;
            op_funct3_q   <= '0;
            op_funct7_5_q <= 1'b0;
            op_add_op_q   <= 1'b0;
        end else if (accept) begin
            op_rs1_q      <= id_rs1;
            op_rs2_q      <= id_rs2;
            op_rd_q       <= id_rd;
            op_we_q       <= id_reg_write;
            op_ctrl_q     <= id_ialu_ctrl;
            op_funct3_q   <= id_funct3;
            op_funct7_5_q <= id_funct7_5;
            op_add_op_q   <= id_add_op;
        end
    end

    // wb_data/wb_rd hold until the next beat; strobes and flags drop after one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid       <= 1'b0;
            wb_we          <= 1'b0;
            wb_rd          <= '0;
            wb_data        <= '0;
            wb_overflow    <= 1'b0;
            wb_div_by_zero <= 1'b0;
            wb_div_timeout <= 1'b0;
        end else begin
            wb_valid <= capt_fire;
            if (capt_fire) begin
                wb_we          <= op_we_q && (op_ctrl_q <= 3'b101) && !div_to_q;
                wb_rd          <= op_rd_q;
                wb_data        <= alu_result;
                wb_overflow    <= alu_overflow && (op_ctrl_q == CtrlAdd);
                wb_div_by_zero <= div_bz_q;
                wb_div_timeout <= div_to_q;
            end else begin
                wb_we          <= 1'b0;
                wb_overflow    <= 1'b0;
                wb_div_by_zero <= 1'b0;
                wb_div_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ialu_issue_ctrl.sv
module tb_ialu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_rs1 = '0, id_rs2 = '0;
    logic [4:0]  id_rd = '0;
    logic        id_reg_write = 1'b0;
    logic [2:0]  id_ialu_ctrl = '0, id_funct3 = '0;
    logic        id_funct7_5 = 1'b0, id_add_op = 1'b0;
    logic [31:0] alu_result;
    logic        alu_overflow;
    logic        alu_div_done = 1'b0, alu_div_by_zero = 1'b0;

    // Main DUT (DIV_TIMEOUT = 64)
    logic        id_ready, alu_funct7_5, alu_add_op;
    logic [31:0] alu_rs1, alu_rs2;
    logic [2:0]  alu_ctrl, alu_funct3;
    logic        wb_valid, wb_we, wb_overflow, wb_div_by_zero, wb_div_timeout;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    // Short-timeout DUT (DIV_TIMEOUT = 8), same stimulus
    logic        t_id_ready, t_alu_funct7_5, t_alu_add_op;
    logic [31:0] t_alu_rs1, t_alu_rs2;
    logic [2:0]  t_alu_ctrl, t_alu_funct3;
    logic        t_wb_valid, t_wb_we, t_wb_overflow, t_wb_div_by_zero, t_wb_div_timeout;
    logic [4:0]  t_wb_rd;
    logic [31:0] t_wb_data;

    always #5 clk = ~clk;

    ialu_issue_ctrl #(.XLEN(32), .REG_AW(5), .DIV_TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_ialu_ctrl(id_ialu_ctrl), .id_funct3(id_funct3), .id_funct7_5(id_funct7_5),
        .id_add_op(id_add_op), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_ctrl(alu_ctrl),
        .alu_funct3(alu_funct3), .alu_funct7_5(alu_funct7_5), .alu_add_op(alu_add_op),
        .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_div_done(alu_div_done),
        .alu_div_by_zero(alu_div_by_zero), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_overflow(wb_overflow), .wb_div_by_zero(wb_div_by_zero),
        .wb_div_timeout(wb_div_timeout)
    );

    ialu_issue_ctrl #(.XLEN(32), .REG_AW(5), .DIV_TIMEOUT(8)) dut_t (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_ready(t_id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_ialu_ctrl(id_ialu_ctrl), .id_funct3(id_funct3), .id_funct7_5(id_funct7_5),
        .id_add_op(id_add_op), .alu_rs1(t_alu_rs1), .alu_rs2(t_alu_rs2), .alu_ctrl(t_alu_ctrl),
        .alu_funct3(t_alu_funct3), .alu_funct7_5(t_alu_funct7_5), .alu_add_op(t_alu_add_op),
        .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_div_done(alu_div_done),
        .alu_div_by_zero(alu_div_by_zero), .wb_valid(t_wb_valid), .wb_we(t_wb_we),
        .wb_rd(t_wb_rd), .wb_data(t_wb_data), .wb_overflow(t_wb_overflow),
        .wb_div_by_zero(t_wb_div_by_zero), .wb_div_timeout(t_wb_div_timeout)
    );

    // Small registered ALU model: add and divide only, zero otherwise.
    logic [31:0] add_sum;
    assign add_sum = alu_rs1 + alu_rs2;
    always_ff @(posedge clk) begin
        case (alu_ctrl)
            3'b000: begin
                alu_result   <= add_sum;
                alu_overflow <= (alu_rs1[31] == alu_rs2[31]) && (add_sum[31] != alu_rs1[31]);
            end
            3'b010: begin
                alu_result   <= (alu_rs2 == 0) ? 32'hFFFF_FFFF : alu_rs1 / alu_rs2;
                alu_overflow <= 1'b0;
            end
            default: begin
                alu_result   <= '0;
                alu_overflow <= 1'b0;
            end
        endcase
    end

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Results of the last run_op
    int          r_wb_cyc, r_beats, r_ctrl_cnt, r_ctrl_last, r_ready_cyc;
    logic [31:0] r_data;
    logic [4:0]  r_rd;
    logic        r_we, r_ovf, r_dz, r_to;

    // Issue one op in cycle 0 and observe 80 cycles on the selected DUT.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctrl,
                          input logic [4:0] rd, input logic rw, input int done_k,
                          input logic dbz, input int flush_k, input logic sel);
        logic v;
        logic rdy;
        logic [2:0] ac;
        r_wb_cyc = -1; r_beats = 0; r_ctrl_cnt = 0; r_ctrl_last = -1; r_ready_cyc = -1;
        r_data = '0; r_rd = '0; r_we = 1'b0; r_ovf = 1'b0; r_dz = 1'b0; r_to = 1'b0;
        @(posedge clk); #1;
        id_valid = 1'b1; id_rs1 = a; id_rs2 = b; id_ialu_ctrl = ctrl; id_rd = rd;
        id_reg_write = rw; id_add_op = 1'b1; id_funct3 = 3'b000; id_funct7_5 = 1'b0;
        alu_div_done = 1'b0; alu_div_by_zero = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("accept_ready", 32'(sel ? t_id_ready : id_ready), 32'd1);
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); #1;
            id_valid        = 1'b0;
            alu_div_done    = (c == done_k);
            alu_div_by_zero = dbz;
            flush           = (c == flush_k);
            @(negedge clk);
            v   = sel ? t_wb_valid : wb_valid;
            rdy = sel ? t_id_ready : id_ready;
            ac  = sel ? t_alu_ctrl : alu_ctrl;
            if (ac == ctrl && ctrl != 3'b111) begin
                r_ctrl_cnt++;
                r_ctrl_last = c;
            end
            if (rdy && r_ready_cyc < 0) r_ready_cyc = c;
            if (v) begin
                r_beats++;
                if (r_wb_cyc < 0) begin
                    r_wb_cyc = c;
                    r_data = sel ? t_wb_data : wb_data;
                    r_rd   = sel ? t_wb_rd : wb_rd;
                    r_we   = sel ? t_wb_we : wb_we;
                    r_ovf  = sel ? t_wb_overflow : wb_overflow;
                    r_dz   = sel ? t_wb_div_by_zero : wb_div_by_zero;
                    r_to   = sel ? t_wb_div_timeout : wb_div_timeout;
                end
            end
        end
        flush = 1'b0; alu_div_done = 1'b0; alu_div_by_zero = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_alu_ctrl", 32'(alu_ctrl), 32'h7);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_alu_rs1", alu_rs1, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_id_ready", 32'(id_ready), 32'd1);

        // ADD 5+7 -> rd 3
        run_op(32'd5, 32'd7, 3'b000, 5'd3, 1'b1, -1, 1'b0, -1, 1'b0);
        check("add_wb_cyc", 32'(r_wb_cyc), 32'd3);
        check("add_beats", 32'(r_beats), 32'd1);
        check("add_data", r_data, 32'd12);
        check("add_rd", 32'(r_rd), 32'd3);
        check("add_we", 32'(r_we), 32'd1);
        check("add_ovf", 32'(r_ovf), 32'd0);
        check("add_ctrl_cnt", 32'(r_ctrl_cnt), 32'd1);
        check("add_ready_cyc", 32'(r_ready_cyc), 32'd3);
        check("add_wb_hold", wb_data, 32'd12);
        check("add_we_drop", 32'(wb_we), 32'd0);

        // Signed overflow
        run_op(32'h7FFF_FFFF, 32'd1, 3'b000, 5'd4, 1'b1, -1, 1'b0, -1, 1'b0);
        check("ovf_data", r_data, 32'h8000_0000);
        check("ovf_flag", 32'(r_ovf), 32'd1);

        // DIV 100/7, done in cycle 10
        run_op(32'd100, 32'd7, 3'b010, 5'd5, 1'b1, 10, 1'b0, -1, 1'b0);
        check("div_wb_cyc", 32'(r_wb_cyc), 32'd12);
        check("div_data", r_data, 32'd14);
        check("div_ctrl_cnt", 32'(r_ctrl_cnt), 32'd10);
        check("div_ctrl_last", 32'(r_ctrl_last), 32'd10);
        check("div_ready_cyc", 32'(r_ready_cyc), 32'd12);
        check("div_we", 32'(r_we), 32'd1);
        check("div_dz", 32'(r_dz), 32'd0);
        check("div_to", 32'(r_to), 32'd0);

        // Divide by zero, done in cycle 5
        run_op(32'd9, 32'd0, 3'b010, 5'd6, 1'b1, 5, 1'b1, -1, 1'b0);
        check("dbz_wb_cyc", 32'(r_wb_cyc), 32'd7);
        check("dbz_flag", 32'(r_dz), 32'd1);
        check("dbz_we", 32'(r_we), 32'd1);
        check("dbz_data", r_data, 32'hFFFF_FFFF);

        // Timeout on the DIV_TIMEOUT=8 instance, done never asserts
        run_op(32'd50, 32'd5, 3'b010, 5'd7, 1'b1, -1, 1'b0, -1, 1'b1);
        check("to_wb_cyc", 32'(r_wb_cyc), 32'd11);
        check("to_flag", 32'(r_to), 32'd1);
        check("to_we", 32'(r_we), 32'd0);
        check("to_beats", 32'(r_beats), 32'd1);

        // Flush during DIV_WAIT in cycle 4
        run_op(32'd100, 32'd7, 3'b010, 5'd8, 1'b1, -1, 1'b0, 4, 1'b0);
        check("fl_beats", 32'(r_beats), 32'd0);
        check("fl_ctrl_last", 32'(r_ctrl_last), 32'd4);
        check("fl_ready_cyc", 32'(r_ready_cyc), 32'd5);

        // Flush during CAPT suppresses the beat
        run_op(32'd1, 32'd2, 3'b000, 5'd9, 1'b1, -1, 1'b0, 2, 1'b0);
        check("flc_beats", 32'(r_beats), 32'd0);
        check("flc_ready_cyc", 32'(r_ready_cyc), 32'd3);

        // No-result code 110
        run_op(32'd1, 32'd2, 3'b110, 5'd10, 1'b1, -1, 1'b0, -1, 1'b0);
        check("nr_wb_cyc", 32'(r_wb_cyc), 32'd3);
        check("nr_we", 32'(r_we), 32'd0);

        // div_done outside DIV_WAIT is ignored
        run_op(32'd3, 32'd4, 3'b000, 5'd11, 1'b1, 1, 1'b1, -1, 1'b0);
        check("ign_wb_cyc", 32'(r_wb_cyc), 32'd3);
        check("ign_dz", 32'(r_dz), 32'd0);
        check("ign_data", r_data, 32'd7);

        // Async reset mid-op
        @(posedge clk); #1;
        id_valid = 1'b1; id_rs1 = 32'd77; id_rs2 = 32'd3; id_ialu_ctrl = 3'b010;
        id_rd = 5'd12; id_reg_write = 1'b1;
        @(posedge clk); #1;
        id_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_ctrl_busy", 32'(alu_ctrl), 32'h2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ctrl", 32'(alu_ctrl), 32'h7);
        check("mid_rst_rs1", alu_rs1, 32'd0);
        check("mid_rst_wb_data", wb_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rel_ready", 32'(id_ready), 32'd1);
        check("mid_rel_wb_valid", 32'(wb_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
